fetch_unit: RTL and testbench

Instruction-fetch sequencer sitting directly upstream of the PC and IR registers in the Mini SRC datapath. On a `start` request it reads the word addressed by the current PC from instruction memory over a ready/ack handshake, then in a single cycle loads the IR with that word and the PC with PC+1. It supports memory wait states, a bounded-wait timeout fault, and a flush for branch redirection.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory read handshake bundle (address, request,
//            ack, read data) shared by the fetch sequencer and memory.
// Revision : 1.0
// ============================================================================
interface fetch_unit_if #(
    parameter int MEM_AW = 9
);
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch sequencer: reads the word at PC over a
//            ready/ack handshake, then loads IR and PC+1 in one cycle.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int MEM_AW  = 9,
    parameter int TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic        flush,
    input  wire logic [31:0] pc_q,
    output logic             pc_load,
    output logic [31:0]      pc_d,
    output logic             ir_load,
    output logic [31:0]      ir_d,
    output logic             busy,
    output logic             done,
    output logic             fault,
    fetch_unit_if.master     mem
);
    localparam int c_WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         pc_cap_q, pc_cap_d;
    logic [31:0]         mdr_q, mdr_d;
    logic [c_WCNT_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        state_d  = state_q;
        pc_cap_d = pc_cap_q;
        mdr_d    = mdr_q;
        wcnt_d   = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_cap_d = pc_q;
                    wcnt_d   = '0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                // Flush beats a same-cycle ack; ack beats the timeout.
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (mem.mem_ack) begin
                    mdr_d   = mem.mem_rdata;
                    state_d = ST_LOAD;
                end else if (wcnt_q == c_WCNT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    wcnt_d = wcnt_q + c_WCNT_W'(1);
                end
            end
            ST_LOAD:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe and never see an input combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_cap_q     <= '0;
            mdr_q        <= '0;
            wcnt_q       <= '0;
            pc_load      <= 1'b0;
            pc_d         <= '0;
            ir_load      <= 1'b0;
            ir_d         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
        end else begin
            state_q      <= state_d;
            pc_cap_q     <= pc_cap_d;
            mdr_q        <= mdr_d;
            wcnt_q       <= wcnt_d;
            pc_load      <= (state_d == ST_LOAD);
            pc_d         <= (state_d == ST_LOAD) ? pc_cap_d + 32'd1 : 32'd0;
            ir_load      <= (state_d == ST_LOAD);
            ir_d         <= (state_d == ST_LOAD) ? mdr_d : 32'd0;
            busy         <= (state_d == ST_READ) || (state_d == ST_LOAD);
            done         <= (state_d == ST_LOAD);
            fault        <= (state_d == ST_FAULT);
            mem.mem_rd   <= (state_d == ST_READ);
            mem.mem_addr <= (state_d == ST_READ) ? pc_cap_d[MEM_AW-1:0] : '0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: directed vector table,
//            hand sequences for reset, and randomized fetches vs a model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;
    localparam int MEM_AW = 9;
    localparam int TO     = 8;
    localparam int LOOP   = TO + 5;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [31:0] pc_q;
    logic        pc_load, ir_load, busy, done, fault;
    logic [31:0] pc_d, ir_d;

    int checks = 0;
    int errors = 0;

    fetch_unit_if #(.MEM_AW(MEM_AW)) mif ();

    fetch_unit #(.MEM_AW(MEM_AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .pc_q(pc_q),
        .pc_load(pc_load), .pc_d(pc_d), .ir_load(ir_load), .ir_d(ir_d),
        .busy(busy), .done(done), .fault(fault), .mem(mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          waits;     // cycles of READ before ack; >= TO means none
        int          flush_at;  // READ-relative cycle of flush, -1 = none
        int          start_at;  // stray start pulse cycle, -1 = none
        int          exp_rd;
        int          exp_busy;
        bit          exp_load;
        logic [31:0] exp_ir;
        logic [31:0] exp_pcd;
        bit          exp_fault;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Transaction-level outcome from the fetch rules: flush, then ack, then timeout.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_load = 1'b0; r.exp_fault = 1'b0; r.exp_ir = '0; r.exp_pcd = '0;
        if (v.flush_at >= 0 && v.flush_at <= v.waits && v.flush_at < TO) begin
            r.exp_rd = v.flush_at + 1; r.exp_busy = r.exp_rd;
        end else if (v.waits < TO) begin
            r.exp_rd = v.waits + 1; r.exp_busy = r.exp_rd + 1;
            r.exp_load = 1'b1; r.exp_ir = v.rdata; r.exp_pcd = v.pc + 32'd1;
        end else begin
            r.exp_rd = TO; r.exp_busy = TO; r.exp_fault = 1'b1;
        end
        return r;
    endfunction

    task automatic idle_inputs();
        start = 1'b0; flush = 1'b0; pc_q = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            start = $urandom_range(0, 1); flush = $urandom_range(0, 1);
            pc_q = $urandom; mif.mem_ack = $urandom_range(0, 1); mif.mem_rdata = $urandom;
            @(posedge clk); #1;
            check("rst_data_zero", {pc_d, ir_d}, 64'd0);
            check("rst_ctrl_zero", {mif.mem_addr, mif.mem_rd, pc_load, ir_load, busy, done, fault}, 64'd0);
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic run_fetch(input string tag, input vec_t v);
        int rd_n = 0, busy_n = 0, load_n = 0, addr_bad = 0, zero_bad = 0;
        logic [31:0] got_ir = '0, got_pcd = '0;
        logic        last_fault = 1'b0;
        start = 1'b1; pc_q = v.pc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < LOOP; c++) begin
            mif.mem_ack   = (c == v.waits);
            mif.mem_rdata = (c == v.waits) ? v.rdata : $urandom;
            flush         = (c == v.flush_at);
            start         = (c == v.start_at);
            pc_q          = $urandom;
            if (mif.mem_rd) begin
                rd_n++;
                if (mif.mem_addr != v.pc[MEM_AW-1:0]) addr_bad++;
            end else if (mif.mem_addr != '0) zero_bad++;
            if (busy) busy_n++;
            if (ir_load) begin
                load_n++; got_ir = ir_d; got_pcd = pc_d;
                if (!pc_load || !done) zero_bad++;
            end else if (pc_load || done || ir_d != 0 || pc_d != 0) zero_bad++;
            last_fault = fault;
            @(posedge clk); #1;
        end
        idle_inputs();
        check({tag, "_rd_cycles"}, rd_n, v.exp_rd);
        check({tag, "_addr"}, addr_bad, 0);
        check({tag, "_busy_cycles"}, busy_n, v.exp_busy);
        check({tag, "_loads"}, load_n, v.exp_load ? 1 : 0);
        check({tag, "_idle_zero"}, zero_bad, 0);
        check({tag, "_fault"}, last_fault, v.exp_fault);
        if (v.exp_load) begin
            check({tag, "_ir_d"}, got_ir, v.exp_ir);
            check({tag, "_pc_d"}, got_pcd, v.exp_pcd);
        end
        if (v.exp_fault || last_fault) begin
            apply_reset(1);
            check({tag, "_fault_cleared"}, fault, 1'b0);
        end
    endtask

    vec_t tbl[8];

    initial begin
        //        pc            rdata         wt   fl  st  rd busy ld ir            pcd           flt
        tbl[0] = '{32'h00000010, 32'hA1B2C3D4, 0,  -1, -1, 1, 2, 1, 32'hA1B2C3D4, 32'h00000011, 0};
        tbl[1] = '{32'h00000020, 32'hDEADBEEF, 3,  -1, 1,  4, 5, 1, 32'hDEADBEEF, 32'h00000021, 0};
        tbl[2] = '{32'hFFFFFFFF, 32'h12345678, 0,  -1, -1, 1, 2, 1, 32'h12345678, 32'h00000000, 0};
        tbl[3] = '{32'h00000040, 32'h0BADF00D, 2,  2,  2,  3, 3, 0, 32'h0,        32'h0,        0};
        tbl[4] = '{32'h00000041, 32'h11111111, 99, 0,  -1, 1, 1, 0, 32'h0,        32'h0,        0};
        tbl[5] = '{32'h00000080, 32'h22222222, 99, -1, 9,  8, 8, 0, 32'h0,        32'h0,        1};
        tbl[6] = '{32'h000001FE, 32'h33333333, 7,  -1, 8,  8, 9, 1, 32'h33333333, 32'h000001FF, 0};
        tbl[7] = '{32'h00000100, 32'h44444444, 8,  -1, -1, 8, 8, 0, 32'h0,        32'h0,        1};

        idle_inputs();
        reset = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_idle", {busy, mif.mem_rd, fault}, 64'd0);
        end

        foreach (tbl[i]) run_fetch($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of READ, then a stray ack must not wake the unit.
        start = 1'b1; pc_q = 32'h33;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midread_rd", mif.mem_rd, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midread_rst_data", {pc_d, ir_d}, 64'd0);
        check("midread_rst_ctrl", {mif.mem_addr, mif.mem_rd, pc_load, ir_load, busy, done, fault}, 64'd0);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stray_ack_idle", {busy, ir_load, pc_load, mif.mem_rd}, 64'd0);
        idle_inputs();

        for (int n = 0; n < 40; n++) begin
            vec_t v;
            v.pc       = $urandom;
            v.rdata    = $urandom;
            v.waits    = $urandom_range(0, 10);
            v.flush_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
            v.start_at = -1;
            v = model(v);
            if ($urandom_range(0, 1) == 1) v.start_at = $urandom_range(0, v.exp_busy - 1);
            run_fetch($sformatf("rnd%0d", n), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
